// File: rtl/car_pkg.sv
// Shared types for the car motion controllers: FSM states, motor command codes, retry width.
// Latency: n/a (declarations only).  Backpressure: n/a.
package car_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CRUISE,
    ST_HALT,
    ST_BACK,
    ST_TURN,
    ST_CHECK,
    ST_FAULT
  } state_t;

  localparam logic [2:0] MOT_STOP  = 3'd0;
  localparam logic [2:0] MOT_FWD   = 3'd1;
  localparam logic [2:0] MOT_REV   = 3'd2;
  localparam logic [2:0] MOT_LEFT  = 3'd3;
  localparam logic [2:0] MOT_RIGHT = 3'd4;

  localparam int RETRY_W = 4;

endpackage

// File: rtl/barrier_avoid_ctrl_if.sv
// Command/status bundle between the obstacle sequencer and its environment.
// Latency: n/a (wiring only).  Backpressure: none, level signals only.
interface barrier_avoid_ctrl_if;
  logic       start;
  logic       barrier;
  logic [2:0] motion;
  logic       busy;
  logic       fault;
  logic [7:0] avoid_cnt;

  modport master (output start, output barrier,
                  input motion, input busy, input fault, input avoid_cnt);
  modport slave  (input start, input barrier,
                  output motion, output busy, output fault, output avoid_cnt);
endinterface

// File: rtl/barrier_avoid_ctrl_dwell_timer.sv
// Dwell timer: loadable down-counter that stops at zero; done flags a zero count.
// Latency: load takes effect on the next edge.  Backpressure: none.
module dwell_timer #(
  parameter int CNT_W = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/barrier_avoid_ctrl.sv
// Obstacle-avoidance sequencer: cruise, then halt/reverse/turn/re-check with retry limit and fault latch.
// Latency: outputs registered, one edge after the deciding input.  Backpressure: none.
// BARRIER_AVOID_ALT_TURN_EN alternates the turn direction (RIGHT first); otherwise always RIGHT.
import car_pkg::*;

module barrier_avoid_ctrl #(
  parameter int STOP_CYC  = 25_000_000,
  parameter int BACK_CYC  = 50_000_000,
  parameter int TURN_CYC  = 40_000_000,
  parameter int MAX_RETRY = 3,
  parameter int CNT_W     = 27
) (
  input  logic              clk,
  input  logic              rst,
  barrier_avoid_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] STOP_VAL = CNT_W'(STOP_CYC - 1);
  localparam logic [CNT_W-1:0] BACK_VAL = CNT_W'(BACK_CYC - 1);
  localparam logic [CNT_W-1:0] TURN_VAL = CNT_W'(TURN_CYC - 1);

  state_t             state_q, state_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [2:0]         motion_q, motion_d;
  logic               busy_q, busy_d;
  logic               fault_q, fault_d;
  logic               tmr_load, tmr_done;
  logic [CNT_W-1:0]   tmr_val;
  logic               clr;
  logic               turn_left_d;

  // Dropping start is indistinguishable from reset, including the timer.
  assign clr = rst | ~bus.start;

  dwell_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (clr),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    state_d  = state_q;
    retry_d  = retry_q;
    cnt_d    = cnt_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (clr) begin
      state_d = ST_IDLE;
      retry_d = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = ST_CRUISE;
        ST_CRUISE: if (bus.barrier) begin
                     state_d  = ST_HALT;
                     tmr_load = 1'b1;
                     tmr_val  = STOP_VAL;
                   end
        ST_HALT:   if (tmr_done) begin
                     state_d  = ST_BACK;
                     tmr_load = 1'b1;
                     tmr_val  = BACK_VAL;
                   end
        ST_BACK:   if (tmr_done) begin
                     state_d  = ST_TURN;
                     tmr_load = 1'b1;
                     tmr_val  = TURN_VAL;
                   end
        ST_TURN:   if (tmr_done) state_d = ST_CHECK;
        ST_CHECK: begin
          if (!bus.barrier) begin
            state_d = ST_CRUISE;
            retry_d = '0;
            cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
          end else if (int'(retry_q) + 1 < MAX_RETRY) begin
            state_d  = ST_HALT;
            retry_d  = retry_q + 1'b1;
            tmr_load = 1'b1;
            tmr_val  = STOP_VAL;
          end else begin
            state_d = ST_FAULT;
          end
        end
        ST_FAULT:  state_d = ST_FAULT;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

`ifdef BARRIER_AVOID_ALT_TURN_EN
  logic turn_left_q;

  always_comb begin
    turn_left_d = turn_left_q;
    if (clr)
      turn_left_d = 1'b0;
    else if (state_q == ST_TURN && tmr_done)
      turn_left_d = ~turn_left_q;
  end

  always_ff @(posedge clk) begin
    if (rst) turn_left_q <= 1'b0;
    else     turn_left_q <= turn_left_d;
  end
`else
  assign turn_left_d = 1'b0;
`endif

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    motion_d = MOT_STOP;
    busy_d   = 1'b0;
    fault_d  = 1'b0;
    case (state_d)
      ST_CRUISE: motion_d = MOT_FWD;
      ST_HALT:   busy_d   = 1'b1;
      ST_BACK:   begin motion_d = MOT_REV; busy_d = 1'b1; end
      ST_TURN:   begin motion_d = turn_left_d ? MOT_LEFT : MOT_RIGHT; busy_d = 1'b1; end
      ST_CHECK:  busy_d   = 1'b1;
      ST_FAULT:  fault_d  = 1'b1;
      default:   motion_d = MOT_STOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      retry_q  <= '0;
      cnt_q    <= '0;
      motion_q <= MOT_STOP;
      busy_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      retry_q  <= retry_d;
      cnt_q    <= cnt_d;
      motion_q <= motion_d;
      busy_q   <= busy_d;
      fault_q  <= fault_d;
    end
  end

  assign bus.motion    = motion_q;
  assign bus.busy      = busy_q;
  assign bus.fault     = fault_q;
  assign bus.avoid_cnt = cnt_q;

endmodule

// File: doc/barrier_avoid_ctrl.md
# barrier_avoid_ctrl

Obstacle-avoidance sequencer directly downstream of the barrier debouncer. It consumes the debounced `barrier` level and emits a registered motion command for the motor driver. While the path is clear the car cruises forward. On a barrier it runs a fixed halt → reverse → turn manoeuvre, then re-checks the path, with a retry limit and a fault latch.

## Interface
- `STOP_CYC`, 25_000_000: cycles held in HALT; must be ≥1.
- `BACK_CYC`, 50_000_000: cycles held in BACK; must be ≥1.
- `TURN_CYC`, 40_000_000: cycles held in TURN; must be ≥1.
- `MAX_RETRY`, 3: consecutive failed re-checks before FAULT; range 1..15.
- `CNT_W`, 27: dwell timer width; must satisfy 2^CNT_W > max(STOP_CYC, BACK_CYC, TURN_CYC).
- `clk`  in  1  system clock; every register is updated on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  enable level; while low, the block behaves exactly as under reset.
- `barrier`  in  1  debounced obstacle level from the upstream debouncer.
- `motion`  out  3  motor command: 3'd0 STOP, 3'd1 FWD, 3'd2 REV, 3'd3 LEFT, 3'd4 RIGHT.
- `busy`  out  1  high while in HALT, BACK, TURN or CHECK.
- `fault`  out  1  high while in FAULT.
- `avoid_cnt`  out  8  number of completed avoidances, saturating at 255.

## Operation
- States: IDLE, CRUISE, HALT, BACK, TURN, CHECK, FAULT.
- If `rst` or `~start` is sampled high, the next state is IDLE with all registers cleared: `motion`=0, `busy`=0, `fault`=0, `avoid_cnt`=0, retry=0, turn direction = RIGHT.
- IDLE: `motion`=STOP. If `start` is high, go to CRUISE.
- CRUISE: `motion`=FWD. If `barrier` is high, go to HALT and load the timer with STOP_CYC−1.
- HALT: `motion`=STOP. When timer==0, go to BACK and load BACK_CYC−1. Otherwise decrement the timer.
- BACK: `motion`=REV. When timer==0, go to TURN and load TURN_CYC−1.
- TURN: `motion`=LEFT or RIGHT according to the turn direction. When timer==0, go to CHECK.
- Each timed state therefore lasts exactly its parameter value in cycles.
- CHECK lasts one cycle with `motion`=STOP. The exit depends on `barrier`:
  - `barrier` low: go to CRUISE, `avoid_cnt`+1 (saturating), retry cleared.
  - `barrier` high and retry+1 < MAX_RETRY: retry+1, go to HALT with STOP_CYC−1 loaded.
  - `barrier` high and retry+1 == MAX_RETRY: go to FAULT.
- FAULT: `motion`=STOP, `fault`=1. The block stays there until `rst` or `~start`.
- `barrier` is ignored in HALT, BACK, TURN and FAULT. It is sampled only in CRUISE and CHECK.
- A `barrier` pulse shorter than one cycle is not possible, because the input is already debounced.
- Retry is a 4-bit counter and cannot overflow given the MAX_RETRY range.

## Timing
- All outputs are registered and are functions of the current state only.
- Latency: `barrier` high sampled at edge k in CRUISE → `motion`=STOP and `busy`=1 from edge k+1.
- Manoeuvre duration: STOP_CYC + BACK_CYC + TURN_CYC + 1 cycles from HALT entry to CRUISE re-entry.
- `start` deasserted mid-manoeuvre → IDLE on the next edge, with all counters cleared.
- `start` and `barrier` both high in IDLE → CRUISE first. HALT follows one cycle later.
- `rst` has priority over every other input.

## Configuration
- `BARRIER_AVOID_ALT_TURN_EN` defined: the turn direction toggles each time TURN is exited. The first turn is RIGHT, then LEFT, RIGHT, and so on. The direction is preserved across CRUISE and cleared only by reset or `~start`.
- Macro undefined: every TURN drives RIGHT and no toggle register is synthesised.

## Structure
- Shared package `car_pkg` holds:
  - the state enum;
  - the `motion` encodings MOT_STOP/FWD/REV/LEFT/RIGHT;
  - the retry counter width.
- One sub-module, `dwell_timer`:
  - ports: `clk`, `rst`, `load`, `load_val[CNT_W-1:0]`, `done`;
  - decrements to zero and holds there;
  - `done` = (count==0).

## Test plan
Bench parameters: STOP_CYC=4, BACK_CYC=8, TURN_CYC=6, MAX_RETRY=3.
- Reset then `start`=1 → `motion`=FWD two edges after `rst` falls; `busy`=0, `avoid_cnt`=0.
- `barrier` pulse of 3 cycles in CRUISE → STOP for 4 cycles, REV for 8, RIGHT for 6, STOP for 1, then FWD; `avoid_cnt`=1.
- `barrier` held high throughout → exactly 3 manoeuvres, then `fault`=1 and `motion`=STOP, held until `start`=0; then `fault`=0 and `avoid_cnt`=0.
- `start` dropped on the 3rd REV cycle → `motion`=STOP and `busy`=0 on the next edge. `start` reasserted → FWD.
- With `BARRIER_AVOID_ALT_TURN_EN` defined, three separate obstacles → turn sequence RIGHT, LEFT, RIGHT. With the macro undefined → RIGHT for all three.
- 260 clear avoidances → `avoid_cnt` saturates at 255.
